// File: rtl/rx_req_pkg.sv
// Shared types for the RX read-request scheduler: requester IDs, FSM states, length width.
package rx_req_pkg;

    localparam int C_LEN_WIDTH = 10;

    typedef enum logic [1:0] {
        SRC_SG_RX = 2'd0,
        SRC_SG_TX = 2'd1,
        SRC_MAIN  = 2'd2
    } src_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/rx_tag_pool.sv
// Completion tag pool: busy vector, per-tag owner table, lowest-free encoder,
// retire with error flag for stray completions, and a registered busy count.
module rx_tag_pool
    import rx_req_pkg::*;
#(
    parameter int C_NUM_TAGS  = 4,
    parameter int C_TAG_WIDTH = $clog2(C_NUM_TAGS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   alloc,
    input  src_t                   alloc_src,
    output logic                   free_avail,
    output logic [C_TAG_WIDTH-1:0] free_tag,
    input  logic [C_TAG_WIDTH-1:0] cpl_tag,
    input  logic                   cpl_done,
    output src_t                   cpl_src,
    output logic                   cpl_err,
    output logic [C_TAG_WIDTH:0]   tags_busy
);

    logic [C_NUM_TAGS-1:0]  busy_reg;
    logic [C_NUM_TAGS-1:0]  busy_next;
    logic [C_NUM_TAGS-1:0]  set_vec;
    logic [C_NUM_TAGS-1:0]  clr_vec;
    logic                   cpl_err_reg;
    logic [C_TAG_WIDTH:0]   tags_busy_reg;
    src_t                   owner_reg [C_NUM_TAGS];

    function automatic logic [C_TAG_WIDTH:0] popcount(input logic [C_NUM_TAGS-1:0] v);
        logic [C_TAG_WIDTH:0] n;
        n = '0;
        for (int i = 0; i < C_NUM_TAGS; i++) begin
            n = n + {{C_TAG_WIDTH{1'b0}}, v[i]};
        end
        return n;
    endfunction

    // Scan from the top so the lowest free index is the one left standing.
    always_comb begin
        free_tag = '0;
        for (int i = C_NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_reg[i]) begin
                free_tag = C_TAG_WIDTH'(i);
            end
        end
    end

    assign free_avail = ~&busy_reg;

    genvar gi;
    generate
        for (gi = 0; gi < C_NUM_TAGS; gi++) begin : g_tag
            assign set_vec[gi] = alloc && free_avail && (free_tag == C_TAG_WIDTH'(gi));
            assign clr_vec[gi] = cpl_done && busy_reg[gi] && (cpl_tag == C_TAG_WIDTH'(gi));
        end
    endgenerate

    // Alloc picks from the pre-retire vector, so set and clear never hit the same bit.
    assign busy_next = (busy_reg & ~clr_vec) | set_vec;

    always_ff @(posedge CLK) begin
        if (RST) begin
            busy_reg      <= '0;
            cpl_err_reg   <= 1'b0;
            tags_busy_reg <= '0;
        end else begin
            busy_reg      <= busy_next;
            cpl_err_reg   <= cpl_done && !busy_reg[cpl_tag];
            tags_busy_reg <= popcount(busy_next);
        end
    end

    always_ff @(posedge CLK) begin
        if (alloc && free_avail) begin
            owner_reg[free_tag] <= alloc_src;
        end
    end

    assign cpl_src   = owner_reg[cpl_tag];
    assign cpl_err   = cpl_err_reg;
    assign tags_busy = tags_busy_reg;

endmodule

// File: rtl/rx_req_tag_scheduler.sv
// Arbitrates SG RX / SG TX / MAIN read requests onto the TX engine request port,
// tagging each request from the pool and giving MAIN a turn after a run of SG grants.
module rx_req_tag_scheduler
    import rx_req_pkg::*;
#(
    parameter int C_NUM_TAGS    = 4,
    parameter int C_TAG_WIDTH   = $clog2(C_NUM_TAGS),
    parameter int C_MAIN_STARVE = 4
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   SG_RX_REQ,
    input  logic [63:0]            SG_RX_ADDR,
    input  logic [C_LEN_WIDTH-1:0] SG_RX_LEN,
    output logic                   SG_RX_REQ_ACK,
    input  logic                   SG_TX_REQ,
    input  logic [63:0]            SG_TX_ADDR,
    input  logic [C_LEN_WIDTH-1:0] SG_TX_LEN,
    output logic                   SG_TX_REQ_ACK,
    input  logic                   MAIN_REQ,
    input  logic [63:0]            MAIN_ADDR,
    input  logic [C_LEN_WIDTH-1:0] MAIN_LEN,
    output logic                   MAIN_REQ_ACK,
    output logic                   RX_REQ,
    input  logic                   RX_REQ_ACK,
    output logic [C_TAG_WIDTH-1:0] RX_REQ_TAG,
    output logic [63:0]            RX_REQ_ADDR,
    output logic [C_LEN_WIDTH-1:0] RX_REQ_LEN,
    input  logic [C_TAG_WIDTH-1:0] CPL_TAG,
    input  logic                   CPL_DONE,
    output logic [1:0]             CPL_SRC,
    output logic                   CPL_ERR,
    output logic [C_TAG_WIDTH:0]   TAGS_BUSY
);

    localparam int C_STARVE_WIDTH = $clog2(C_MAIN_STARVE + 1);
    localparam logic [C_STARVE_WIDTH-1:0] C_STARVE_MAX = C_STARVE_WIDTH'(C_MAIN_STARVE);

    state_t                   state_reg;
    src_t                     src_reg;
    logic [C_TAG_WIDTH-1:0]   tag_reg;
    logic [63:0]              addr_reg;
    logic [C_LEN_WIDTH-1:0]   len_reg;
    logic                     rx_req_reg;
    logic [C_STARVE_WIDTH-1:0] starve_reg;

    logic                     free_avail;
    logic [C_TAG_WIDTH-1:0]   free_tag;
    logic                     grant;
    logic                     issue_ack;
    src_t                     win_src;
    logic [63:0]              win_addr;
    logic [C_LEN_WIDTH-1:0]   win_len;
    src_t                     pool_cpl_src;
    logic [2:0]               ack_vec;

    assign grant = (state_reg == IDLE) && (SG_RX_REQ || SG_TX_REQ || MAIN_REQ) && free_avail;

    always_comb begin
        win_src = SRC_MAIN;
        if (MAIN_REQ && (starve_reg >= C_STARVE_MAX)) begin
            win_src = SRC_MAIN;
        end else if (SG_RX_REQ) begin
            win_src = SRC_SG_RX;
        end else if (SG_TX_REQ) begin
            win_src = SRC_SG_TX;
        end
        case (win_src)
            SRC_SG_RX: begin win_addr = SG_RX_ADDR; win_len = SG_RX_LEN; end
            SRC_SG_TX: begin win_addr = SG_TX_ADDR; win_len = SG_TX_LEN; end
            default:   begin win_addr = MAIN_ADDR;  win_len = MAIN_LEN;  end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            src_reg    <= SRC_SG_RX;
            tag_reg    <= '0;
            addr_reg   <= '0;
            len_reg    <= '0;
            rx_req_reg <= 1'b0;
            starve_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant) begin
                        state_reg  <= ISSUE;
                        src_reg    <= win_src;
                        tag_reg    <= free_tag;
                        addr_reg   <= win_addr;
                        len_reg    <= win_len;
                        rx_req_reg <= 1'b1;
                        if (win_src == SRC_MAIN) begin
                            starve_reg <= '0;
                        end else if (MAIN_REQ && (starve_reg < C_STARVE_MAX)) begin
                            starve_reg <= starve_reg + 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (RX_REQ_ACK) begin
                        state_reg  <= IDLE;
                        rx_req_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // A reset arriving mid-issue swallows the engine's ack rather than passing it on.
    assign issue_ack = RX_REQ_ACK && (state_reg == ISSUE) && !RST;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_ack
            assign ack_vec[gi] = issue_ack && (src_reg == 2'(gi));
        end
    endgenerate

    assign SG_RX_REQ_ACK = ack_vec[SRC_SG_RX];
    assign SG_TX_REQ_ACK = ack_vec[SRC_SG_TX];
    assign MAIN_REQ_ACK  = ack_vec[SRC_MAIN];

    assign RX_REQ      = rx_req_reg;
    assign RX_REQ_TAG  = tag_reg;
    assign RX_REQ_ADDR = addr_reg;
    assign RX_REQ_LEN  = len_reg;
    assign CPL_SRC     = pool_cpl_src;

    rx_tag_pool #(
        .C_NUM_TAGS  (C_NUM_TAGS),
        .C_TAG_WIDTH (C_TAG_WIDTH)
    ) u_pool (
        .CLK        (CLK),
        .RST        (RST),
        .alloc      (grant),
        .alloc_src  (win_src),
        .free_avail (free_avail),
        .free_tag   (free_tag),
        .cpl_tag    (CPL_TAG),
        .cpl_done   (CPL_DONE),
        .cpl_src    (pool_cpl_src),
        .cpl_err    (CPL_ERR),
        .tags_busy  (TAGS_BUSY)
    );

endmodule

// File: tb/tb_rx_req_tag_scheduler.sv
// Bench for rx_req_tag_scheduler: directed vector table, corner sequences, and
// random traffic checked every cycle against a transaction-level model.
module tb_rx_req_tag_scheduler;

    localparam int NT     = 4;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sg_rx_req, sg_tx_req, main_req;
    logic [63:0] sg_rx_addr, sg_tx_addr, main_addr;
    logic [9:0]  sg_rx_len, sg_tx_len, main_len;
    logic        sg_rx_ack, sg_tx_ack, main_ack;
    logic        rx_req, rx_req_ack;
    logic [1:0]  rx_req_tag;
    logic [63:0] rx_req_addr;
    logic [9:0]  rx_req_len;
    logic [1:0]  cpl_tag;
    logic        cpl_done;
    logic [1:0]  cpl_src;
    logic        cpl_err;
    logic [2:0]  tags_busy;

    rx_req_tag_scheduler #(.C_NUM_TAGS(NT), .C_MAIN_STARVE(STARVE)) dut (
        .CLK(clk), .RST(rst),
        .SG_RX_REQ(sg_rx_req), .SG_RX_ADDR(sg_rx_addr), .SG_RX_LEN(sg_rx_len), .SG_RX_REQ_ACK(sg_rx_ack),
        .SG_TX_REQ(sg_tx_req), .SG_TX_ADDR(sg_tx_addr), .SG_TX_LEN(sg_tx_len), .SG_TX_REQ_ACK(sg_tx_ack),
        .MAIN_REQ(main_req), .MAIN_ADDR(main_addr), .MAIN_LEN(main_len), .MAIN_REQ_ACK(main_ack),
        .RX_REQ(rx_req), .RX_REQ_ACK(rx_req_ack), .RX_REQ_TAG(rx_req_tag),
        .RX_REQ_ADDR(rx_req_addr), .RX_REQ_LEN(rx_req_len),
        .CPL_TAG(cpl_tag), .CPL_DONE(cpl_done), .CPL_SRC(cpl_src), .CPL_ERR(cpl_err),
        .TAGS_BUSY(tags_busy)
    );

    int tests = 0;
    int fails = 0;
    bit model_on = 0;
    logic [2:0] obs_ack;  // {main, sg_tx, sg_rx} as seen in the last settled cycle

    // Transaction-level reference: one outstanding request, a set of busy tags with owners.
    bit          m_pend;
    int          m_src, m_tag, m_len, m_starve;
    logic [63:0] m_addr;
    bit [NT-1:0] m_busy;
    int          m_owner [NT];
    bit          m_err;

    typedef struct {
        logic [2:0] req;
        logic       ack;
        logic       done;
        logic [1:0] ctag;
        logic       chk_src;
        logic [1:0] exp_src;
        logic       exp_rx;
        logic [1:0] exp_tag;
        logic [9:0] exp_len;
        logic [2:0] exp_ack;
        logic [2:0] exp_busy;
        logic       exp_err;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic [2:0] req, logic ack, logic done, logic [1:0] ctag,
                                logic chk, logic [1:0] esrc, logic erx, logic [1:0] etag,
                                logic [9:0] elen, logic [2:0] eack, logic [2:0] ebusy, logic eerr);
        vec_t v;
        v.req = req; v.ack = ack; v.done = done; v.ctag = ctag; v.chk_src = chk; v.exp_src = esrc;
        v.exp_rx = erx; v.exp_tag = etag; v.exp_len = elen; v.exp_ack = eack;
        v.exp_busy = ebusy; v.exp_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        check("rx_req", rx_req, m_pend);
        check("rx_req_tag", rx_req_tag, m_tag);
        check("rx_req_addr", rx_req_addr, m_addr);
        check("rx_req_len", rx_req_len, m_len);
        check("sg_rx_ack", sg_rx_ack, m_pend && rx_req_ack && !rst && m_src == 0);
        check("sg_tx_ack", sg_tx_ack, m_pend && rx_req_ack && !rst && m_src == 1);
        check("main_ack", main_ack, m_pend && rx_req_ack && !rst && m_src == 2);
        check("cpl_err", cpl_err, m_err);
        check("tags_busy", tags_busy, $countones(m_busy));
        if (m_busy[cpl_tag]) check("cpl_src", cpl_src, m_owner[cpl_tag]);
    endtask

    task automatic model_step();
        bit [NT-1:0] old;
        int ft, win;
        if (rst) begin
            m_pend = 0; m_tag = 0; m_addr = '0; m_len = 0; m_busy = '0; m_starve = 0; m_err = 0;
            return;
        end
        old   = m_busy;
        m_err = cpl_done && !old[cpl_tag];
        if (m_pend) begin
            if (rx_req_ack) m_pend = 0;
        end else begin
            ft = -1;
            for (int i = NT - 1; i >= 0; i--) if (!old[i]) ft = i;
            if (ft >= 0 && (sg_rx_req || sg_tx_req || main_req)) begin
                if (main_req && m_starve >= STARVE) win = 2;
                else if (sg_rx_req) win = 0;
                else if (sg_tx_req) win = 1;
                else win = 2;
                m_pend = 1; m_src = win; m_tag = ft;
                m_addr = (win == 0) ? sg_rx_addr : (win == 1) ? sg_tx_addr : main_addr;
                m_len  = (win == 0) ? sg_rx_len  : (win == 1) ? sg_tx_len  : main_len;
                m_busy[ft] = 1; m_owner[ft] = win;
                if (win == 2) m_starve = 0;
                else if (main_req && m_starve < STARVE) m_starve++;
            end
        end
        if (cpl_done && old[cpl_tag]) m_busy[cpl_tag] = 0;
    endtask

    task automatic settle();
        #1;
        obs_ack = {main_ack, sg_tx_ack, sg_rx_ack};
        if (model_on) model_check();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        settle();
        edge_step();
    endtask

    task automatic set_req(input int src, input logic v);
        case (src)
            0: sg_rx_req = v;
            1: sg_tx_req = v;
            default: main_req = v;
        endcase
    endtask

    // One complete request from an idle scheduler with an immediate engine ack.
    task automatic req_expect(input int src, input int exp_tag);
        set_req(src, 1'b1);
        cycle();
        check("issue rx_req", rx_req, 1'b1);
        check("issue tag", rx_req_tag, exp_tag);
        rx_req_ack = 1'b1;
        settle();
        check("issue ack", obs_ack, 3'b001 << src);
        edge_step();
        rx_req_ack = 1'b0;
        set_req(src, 1'b0);
    endtask

    initial begin
        logic [2:0] exp_ack;
        rst = 1'b1; rx_req_ack = 1'b0; cpl_done = 1'b0; cpl_tag = '0;
        sg_rx_req = 1'b0; sg_tx_req = 1'b0; main_req = 1'b0;
        sg_rx_addr = 64'h2000; sg_rx_len = 10'd8;
        sg_tx_addr = 64'h3000; sg_tx_len = 10'd16;
        main_addr  = 64'h1000; main_len  = 10'd32;
        cycle(); cycle();
        rst = 1'b0;
        model_on = 1;
        check("reset rx_req", rx_req, 1'b0);
        check("reset tags_busy", tags_busy, 3'd0);
        check("reset tag/addr/len", {rx_req_tag, rx_req_addr[31:0], rx_req_len}, '0);
        check("reset cpl_err", cpl_err, 1'b0);

        // req = {main, sg_tx, sg_rx}; exp_ack uses the same order
        tv.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0, 0,  0, 3'b000, 0, 0));
        tv.push_back(mk(3'b100, 0, 0, 0, 0, 0, 1, 0, 32, 3'b000, 1, 0));
        tv.push_back(mk(3'b100, 0, 0, 0, 0, 0, 1, 0, 32, 3'b000, 1, 0));
        tv.push_back(mk(3'b100, 1, 0, 0, 0, 0, 1, 0, 32, 3'b100, 1, 0));
        tv.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32, 3'b000, 1, 0));
        tv.push_back(mk(3'b000, 0, 1, 0, 1, 2, 0, 0, 32, 3'b000, 1, 0));
        tv.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 32, 3'b000, 0, 0));
        tv.push_back(mk(3'b111, 0, 0, 0, 0, 0, 0, 0, 32, 3'b000, 0, 0));
        tv.push_back(mk(3'b111, 1, 0, 0, 0, 0, 1, 0,  8, 3'b001, 1, 0));
        tv.push_back(mk(3'b110, 0, 0, 0, 0, 0, 0, 0,  8, 3'b000, 1, 0));
        tv.push_back(mk(3'b110, 1, 0, 0, 0, 0, 1, 1, 16, 3'b010, 2, 0));
        tv.push_back(mk(3'b100, 0, 0, 0, 0, 0, 0, 1, 16, 3'b000, 2, 0));
        tv.push_back(mk(3'b100, 1, 0, 0, 0, 0, 1, 2, 32, 3'b100, 3, 0));
        tv.push_back(mk(3'b000, 0, 0, 0, 1, 0, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 0, 1, 1, 1, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 0, 2, 1, 2, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 1, 3, 0, 0, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 2, 32, 3'b000, 3, 1));
        tv.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 1, 0, 1, 0, 0, 2, 32, 3'b000, 3, 0));
        tv.push_back(mk(3'b000, 0, 1, 1, 0, 0, 0, 2, 32, 3'b000, 2, 0));
        tv.push_back(mk(3'b000, 0, 1, 2, 0, 0, 0, 2, 32, 3'b000, 1, 0));
        tv.push_back(mk(3'b000, 0, 0, 0, 0, 0, 0, 2, 32, 3'b000, 0, 0));

        foreach (tv[i]) begin
            {main_req, sg_tx_req, sg_rx_req} = tv[i].req;
            rx_req_ack = tv[i].ack; cpl_done = tv[i].done; cpl_tag = tv[i].ctag;
            settle();
            check($sformatf("tv%0d rx_req", i), rx_req, tv[i].exp_rx);
            check($sformatf("tv%0d tag", i), rx_req_tag, tv[i].exp_tag);
            check($sformatf("tv%0d len", i), rx_req_len, tv[i].exp_len);
            check($sformatf("tv%0d acks", i), obs_ack, tv[i].exp_ack);
            check($sformatf("tv%0d tags_busy", i), tags_busy, tv[i].exp_busy);
            check($sformatf("tv%0d cpl_err", i), cpl_err, tv[i].exp_err);
            if (tv[i].chk_src) check($sformatf("tv%0d cpl_src", i), cpl_src, tv[i].exp_src);
            edge_step();
        end
        rx_req_ack = 1'b0; cpl_done = 1'b0;

        // Pool full: fifth request waits, then takes the tag freed by the completion.
        for (int t = 0; t < 4; t++) req_expect(0, t);
        sg_rx_req = 1'b1;
        repeat (3) cycle();
        check("full rx_req", rx_req, 1'b0);
        check("full tags_busy", tags_busy, 3'd4);
        cpl_tag = 2'd2; cpl_done = 1'b1;
        cycle();
        cpl_done = 1'b0;
        check("refill rx_req early", rx_req, 1'b0);
        cycle();
        check("refill rx_req", rx_req, 1'b1);
        check("refill tag", rx_req_tag, 2'd2);
        check("refill tags_busy", tags_busy, 3'd4);
        rx_req_ack = 1'b1;
        cycle();
        rx_req_ack = 1'b0; sg_rx_req = 1'b0;
        for (int t = 0; t < 4; t++) begin
            cpl_tag = 2'(t); cpl_done = 1'b1;
            cycle();
        end
        cpl_done = 1'b0;
        cycle();

        // Starvation: SG_RX hammers, MAIN waits; MAIN wins the fifth grant.
        sg_rx_req = 1'b1; main_req = 1'b1; rx_req_ack = 1'b1; cpl_tag = 2'd0;
        for (int g = 0; g < 6; g++) begin
            cpl_done = 1'b0;
            cycle();
            cpl_done = 1'b1;
            settle();
            exp_ack = (g == 4) ? 3'b100 : 3'b001;
            check($sformatf("starve grant %0d", g), obs_ack, exp_ack);
            edge_step();
            if (g == 4) main_req = 1'b0;
        end
        sg_rx_req = 1'b0; rx_req_ack = 1'b0; cpl_done = 1'b0;
        cycle();

        // Reset while issuing with three tags busy.
        req_expect(1, 0);
        req_expect(1, 1);
        sg_tx_req = 1'b1;
        cycle();
        check("pre-rst rx_req", rx_req, 1'b1);
        check("pre-rst tags_busy", tags_busy, 3'd3);
        rst = 1'b1; rx_req_ack = 1'b1;
        settle();
        check("rst no ack", obs_ack, 3'b000);
        edge_step();
        rst = 1'b0; rx_req_ack = 1'b0;
        settle();
        check("post-rst rx_req", rx_req, 1'b0);
        check("post-rst tags_busy", tags_busy, 3'd0);
        edge_step();
        check("post-rst reissue", rx_req, 1'b1);
        check("post-rst tag", rx_req_tag, 2'd0);
        rx_req_ack = 1'b1;
        cycle();
        rx_req_ack = 1'b0; sg_tx_req = 1'b0;
        cpl_tag = 2'd0; cpl_done = 1'b1;
        cycle();
        cpl_done = 1'b0;
        cycle();

        // Random legal traffic: requesters hold REQ until acked.
        for (int n = 0; n < 3000; n++) begin
            if (obs_ack[0]) sg_rx_req = 1'b0;
            if (obs_ack[1]) sg_tx_req = 1'b0;
            if (obs_ack[2]) main_req  = 1'b0;
            if (!sg_rx_req && $urandom_range(3) == 0) begin
                sg_rx_req = 1'b1; sg_rx_addr = {$urandom, $urandom}; sg_rx_len = 10'($urandom);
            end
            if (!sg_tx_req && $urandom_range(3) == 0) begin
                sg_tx_req = 1'b1; sg_tx_addr = {$urandom, $urandom}; sg_tx_len = 10'($urandom);
            end
            if (!main_req && $urandom_range(2) == 0) begin
                main_req = 1'b1; main_addr = {$urandom, $urandom}; main_len = 10'($urandom);
            end
            rx_req_ack = ($urandom_range(2) == 0);
            cpl_done   = ($urandom_range(3) == 0);
            cpl_tag    = 2'($urandom);
            rst        = ($urandom_range(499) == 0);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_req_tag_scheduler.md
Name: rx_req_tag_scheduler

Overview:
- Arbitrates the shared PCIe read-request channel between three requesters in an RX port: scatter-gather RX list, scatter-gather TX list, and main data.
- Allocates a completion tag per issued request from a small pool and records which requester owns each tag.
- Frees tags on completion and provides a tag-to-source lookup, so completion data is steered to the correct FIFO packer.
- Sits between the requesters and the TX engine request port.

Parameters:
- C_NUM_TAGS, 4, size of the tag pool; must be a power of 2, range 2..32.
- C_TAG_WIDTH, clog2(C_NUM_TAGS), width of the tag fields.
- C_MAIN_STARVE, 4, number of consecutive SG grants after which MAIN, if requesting, gets top priority once.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- SG_RX_REQ  in  1  SG RX requester wants a read (level).
- SG_RX_ADDR  in  64  SG RX read address.
- SG_RX_LEN  in  10  SG RX read length, in DWORDs.
- SG_RX_REQ_ACK  out  1  one-cycle accept pulse to SG RX.
- SG_TX_REQ, SG_TX_ADDR, SG_TX_LEN, SG_TX_REQ_ACK  in/in/in/out  1/64/10/1  same roles as the SG RX ports, for SG TX.
- MAIN_REQ, MAIN_ADDR, MAIN_LEN, MAIN_REQ_ACK  in/in/in/out  1/64/10/1  same roles as the SG RX ports, for main data.
- RX_REQ  out  1  read request to the TX engine (level).
- RX_REQ_ACK  in  1  TX engine accepted the request.
- RX_REQ_TAG  out  C_TAG_WIDTH  tag of the request.
- RX_REQ_ADDR  out  64  address of the request.
- RX_REQ_LEN  out  10  length of the request.
- CPL_TAG  in  C_TAG_WIDTH  tag of the completion being looked up or retired.
- CPL_DONE  in  1  final completion for CPL_TAG; frees the tag.
- CPL_SRC  out  2  owner of CPL_TAG: 0=SG_RX, 1=SG_TX, 2=MAIN.
- CPL_ERR  out  1  one-cycle pulse when CPL_DONE arrives for a tag that is not in use.
- TAGS_BUSY  out  C_TAG_WIDTH+1  number of tags currently allocated.

Behaviour:
- Reset: state IDLE; all tags free; starve counter 0. RX_REQ, all *_REQ_ACK, CPL_ERR = 0. TAGS_BUSY = 0. RX_REQ_TAG/ADDR/LEN = 0.
- State IDLE:
  - Grant only if at least one *_REQ is high and at least one tag is free.
  - Priority: MAIN if starve count >= C_MAIN_STARVE and MAIN_REQ is high; otherwise SG_RX > SG_TX > MAIN.
  - On grant, register the winner's ADDR/LEN, the owner ID, and the lowest-index free tag. Mark that tag busy and record its owner. Go to ISSUE.
  - RX_REQ rises the cycle after the grant (1-cycle latency from REQ to RX_REQ).
- State ISSUE:
  - RX_REQ=1 with stable tag, address and length until RX_REQ_ACK.
  - Ack pulse is combinational: owner_REQ_ACK = RX_REQ_ACK & (state==ISSUE) & (owner matches).
  - The same cycle, go to IDLE and drop RX_REQ (registered).
  - Requesters drop REQ on the cycle after their ACK, so no double grant occurs.
- Starve counter:
  - Increments (saturating) on each SG grant made while MAIN_REQ is high.
  - Clears on any MAIN grant.
- Tag retire:
  - CPL_DONE with CPL_TAG busy → tag freed at the clock edge.
  - CPL_DONE with CPL_TAG free → tag state unchanged; CPL_ERR pulses 1 cycle (registered).
- CPL_SRC: combinational read of the owner table at CPL_TAG; the value is valid only while that tag is busy.
- Simultaneous alloc and free:
  - Allocation uses the free vector as it stands before this cycle's retire; a tag freed this cycle can be allocated next cycle at the earliest.
  - A free and an alloc of different tags in the same cycle leave TAGS_BUSY unchanged.
- Pool full: IDLE waits, and RX_REQ stays 0, until a tag is freed.
- TAGS_BUSY: registered popcount of the busy vector; range 0..C_NUM_TAGS.
- RST mid-ISSUE: RX_REQ drops the next cycle, all tags are freed, and no ACK is emitted.
- A requester deasserting REQ during ISSUE is illegal; the request is still issued.

Decomposition:
- Package rx_req_pkg holds:
  - the src_t enum (SRC_SG_RX=0, SRC_SG_TX=1, SRC_MAIN=2);
  - the state_t enum (IDLE, ISSUE);
  - the C_LEN_WIDTH=10 constant.
- Sub-module rx_tag_pool holds the busy vector, the owner table, lowest-free priority encoder, the alloc/free ports, CPL_ERR generation and the popcount.
- The top level holds the arbiter FSM and the starve counter.

Test Plan:
- Single MAIN_REQ (addr 0x1000, len 32), RX_REQ_ACK 2 cycles after RX_REQ:
  - RX_REQ rises the cycle after the grant with tag 0, addr 0x1000, len 32.
  - MAIN_REQ_ACK pulses in the RX_REQ_ACK cycle.
  - TAGS_BUSY = 1.
- SG_RX, SG_TX and MAIN all requesting at once, immediate acks:
  - Grant order is SG_RX, SG_TX, MAIN with tags 0, 1, 2.
  - CPL_SRC for CPL_TAG 0/1/2 reads 0/1/2.
- Four back-to-back requests with no completions, then a fifth:
  - Fifth request is held with RX_REQ=0 and TAGS_BUSY=4.
  - CPL_DONE on tag 2 → fifth request issues with tag 2, two cycles later.
- SG_RX held requesting continuously while MAIN requests, C_MAIN_STARVE=4:
  - After 4 SG_RX grants, the 5th grant goes to MAIN.
  - The counter then resets and SG_RX wins again.
- CPL_DONE on a free tag 3:
  - CPL_ERR pulses 1 cycle.
  - TAGS_BUSY is unchanged.
- RST asserted while in ISSUE with 3 tags busy:
  - RX_REQ = 0, TAGS_BUSY = 0, no ACK pulses.
  - Next request gets tag 0.
